// File: rtl/word_asm_pkg.sv
// word_asm_pkg: shared FSM state and requester encodings for word_assembler_arb
package word_asm_pkg;
  typedef enum logic [1:0] {IDLE, FIRST, SECOND, FULL} state_t;
  typedef enum logic {SRC_A, SRC_B} src_t;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-requester round-robin arbiter; req/ptr/update in, gnt out, pointer held internally
module rr_arb2
  import word_asm_pkg::*;
(
  input  logic       clk,
  input  logic       clear,
  input  logic [1:0] req,
  input  src_t       ptr,
  input  logic       update,
  output src_t       gnt
);
  src_t ptr_q, ptr_d;
  always_comb ptr_d = update ? ptr : ptr_q;
  always_ff @(posedge clk) ptr_q <= clear ? SRC_A : ptr_d;
  always_comb gnt = &req ? ptr_q : req[1] ? SRC_B : SRC_A;
endmodule

// File: rtl/word_assembler_arb.sv
// word_assembler_arb: assembles N-bit words from two N/2-bit requesters (a_*/b_* in, valid/ready) under round-robin, word out via out_valid/out_ready with out_src, busy
module word_assembler_arb
  import word_asm_pkg::*;
#(
  parameter int N          = 16,
  parameter bit HIGH_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         a_valid,
  input  logic [N/2-1:0] a_data,
  output logic         a_ready,
  input  logic         b_valid,
  input  logic [N/2-1:0] b_data,
  output logic         b_ready,
  output logic         out_valid,
  output logic [N-1:0] out_data,
  output logic         out_src,
  input  logic         out_ready,
  output logic         busy
);
  localparam int H = N / 2;
  state_t         state_q, state_d;
  src_t           src_q, src_d, gnt, next_ptr;
  logic [H-1:0]   hi_q, hi_d, lo_q, lo_d, byte_in;
  logic           loading, hs, ld_first, ld_second, ld_hi, ld_lo, rel, req_any;
  rr_arb2 u_arb (
    .clk    (clk),
    .clear  (clear),
    .req    ({b_valid, a_valid}),
    .ptr    (next_ptr),
    .update (rel),
    .gnt    (gnt)
  );
  always_comb begin
    req_any   = a_valid | b_valid;
    loading   = (state_q == FIRST) || (state_q == SECOND);
    hs        = (src_q == SRC_B) ? b_valid : a_valid;
    byte_in   = (src_q == SRC_B) ? b_data : a_data;
    ld_first  = (state_q == FIRST) && hs;
    ld_second = (state_q == SECOND) && hs;
    ld_hi     = HIGH_FIRST ? ld_first : ld_second;
    ld_lo     = HIGH_FIRST ? ld_second : ld_first;
    rel       = (state_q == FULL) && out_ready;
    next_ptr  = (src_q == SRC_A) ? SRC_B : SRC_A;
    hi_d      = ld_hi ? byte_in : hi_q;
    lo_d      = ld_lo ? byte_in : lo_q;
    src_d     = (state_q == IDLE && req_any) ? gnt : src_q;
    state_d   = state_q == IDLE   ? (req_any ? FIRST : IDLE) :
                state_q == FIRST  ? (hs ? SECOND : FIRST) :
                state_q == SECOND ? (hs ? FULL : SECOND) :
                                    (out_ready ? IDLE : FULL);
  end
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= IDLE;
      src_q   <= SRC_A;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end
  assign a_ready   = loading && (src_q == SRC_A);
  assign b_ready   = loading && (src_q == SRC_B);
  assign out_valid = state_q == FULL;
  assign out_data  = {hi_q, lo_q};
  assign out_src   = src_q == SRC_B;
  assign busy      = state_q != IDLE;
endmodule

// File: tb/tb_word_assembler_arb.sv
// tb_word_assembler_arb: directed and random checks of both HIGH_FIRST variants against a word-level model
module tb_word_assembler_arb;
  logic clk = 1'b0;
  logic clear = 1'b1, a_valid = 1'b0, b_valid = 1'b0, out_ready = 1'b0;
  logic [7:0] a_data = '0, b_data = '0;
  logic a_ready0, b_ready0, out_valid0, out_src0, busy0;
  logic a_ready1, b_ready1, out_valid1, out_src1, busy1;
  logic [15:0] out_data0, out_data1;
  int checks = 0, passed = 0;
  int m_active = 0, m_got = 0, m_owner = 0, m_ptr = 0;
  logic [15:0] mw0 = '0, mw1 = '0;
  always #5 clk = ~clk;
  word_assembler_arb #(.N(16), .HIGH_FIRST(1'b1)) u0 (
    .clk(clk), .clear(clear),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready0),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready0),
    .out_valid(out_valid0), .out_data(out_data0), .out_src(out_src0),
    .out_ready(out_ready), .busy(busy0)
  );
  word_assembler_arb #(.N(16), .HIGH_FIRST(1'b0)) u1 (
    .clk(clk), .clear(clear),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready1),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready1),
    .out_valid(out_valid1), .out_data(out_data1), .out_src(out_src1),
    .out_ready(out_ready), .busy(busy1)
  );
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask
  task automatic look();
    logic full, load;
    @(negedge clk);
    full = (m_active != 0) && (m_got == 2);
    load = (m_active != 0) && (m_got < 2);
    chk("a_ready0", 16'(a_ready0), 16'(load && m_owner == 0));
    chk("b_ready0", 16'(b_ready0), 16'(load && m_owner == 1));
    chk("out_valid0", 16'(out_valid0), 16'(full));
    chk("out_data0", out_data0, mw0);
    chk("out_src0", 16'(out_src0), 16'(m_owner));
    chk("busy0", 16'(busy0), 16'(m_active != 0));
    chk("a_ready1", 16'(a_ready1), 16'(load && m_owner == 0));
    chk("b_ready1", 16'(b_ready1), 16'(load && m_owner == 1));
    chk("out_valid1", 16'(out_valid1), 16'(full));
    chk("out_data1", out_data1, mw1);
    chk("out_src1", 16'(out_src1), 16'(m_owner));
  endtask
  task automatic tick();
    int act, got, own, ptr;
    logic [15:0] w0, w1;
    logic [7:0] bt;
    act = m_active; got = m_got; own = m_owner; ptr = m_ptr; w0 = mw0; w1 = mw1;
    if (clear) begin
      act = 0; got = 0; own = 0; ptr = 0; w0 = '0; w1 = '0;
    end else if (act == 0) begin
      if (a_valid || b_valid) begin
        act = 1;
        got = 0;
        own = (a_valid && b_valid) ? ptr : (b_valid ? 1 : 0);
      end
    end else if (got < 2) begin
      if (own == 1 ? b_valid : a_valid) begin
        bt = (own == 1) ? b_data : a_data;
        if (got == 0) begin
          w0[15:8] = bt;
          w1[7:0]  = bt;
        end else begin
          w0[7:0]  = bt;
          w1[15:8] = bt;
        end
        got++;
      end
    end else if (out_ready) begin
      act = 0;
      got = 0;
      ptr = 1 - own;
    end
    @(posedge clk);
    #1;
    m_active = act; m_got = got; m_owner = own; m_ptr = ptr; mw0 = w0; mw1 = w1;
  endtask
  task automatic cyc();
    look();
    tick();
  endtask
  task automatic do_clear();
    clear = 1'b1; a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b0;
    tick();
    clear = 1'b0;
  endtask
  initial begin
    int words;
    tick();
    clear = 1'b0;
    look();
    chk("reset_data", out_data0, 16'h0000);
    chk("reset_busy", 16'(busy0), 16'h0);
    tick();
    a_valid = 1'b1; a_data = 8'h12;
    cyc();
    cyc();
    a_data = 8'h34;
    cyc();
    a_valid = 1'b0; out_ready = 1'b1;
    look();
    chk("t1_valid", 16'(out_valid0), 16'h1);
    chk("t1_data", out_data0, 16'h1234);
    chk("t1_src", 16'(out_src0), 16'h0);
    tick();
    look();
    chk("t1_valid_drop", 16'(out_valid0), 16'h0);
    tick();
    do_clear();
    a_valid = 1'b1; b_valid = 1'b1; out_ready = 1'b1;
    words = 0;
    for (int i = 0; i < 16; i++) begin
      a_data = (m_got == 0) ? 8'hA1 : 8'hA2;
      b_data = (m_got == 0) ? 8'hB1 : 8'hB2;
      look();
      if (out_valid0) begin
        chk("t2_src", 16'(out_src0), 16'(words % 2));
        chk("t2_data", out_data0, (words % 2 == 1) ? 16'hB1B2 : 16'hA1A2);
        words++;
      end
      tick();
    end
    chk("t2_words", 16'(words), 16'd4);
    do_clear();
    a_valid = 1'b1; a_data = 8'h55;
    cyc();
    cyc();
    a_data = 8'h66;
    cyc();
    a_valid = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      look();
      chk("t3_hold_data", out_data0, 16'h5566);
      chk("t3_hold_valid", 16'(out_valid0), 16'h1);
      tick();
    end
    out_ready = 1'b1;
    cyc();
    look();
    chk("t3_released", 16'(out_valid0), 16'h0);
    tick();
    do_clear();
    a_valid = 1'b1; b_valid = 1'b1; a_data = 8'h77;
    cyc();
    cyc();
    a_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      look();
      chk("t4_b_ready", 16'(b_ready0), 16'h0);
      chk("t4_busy", 16'(busy0), 16'h1);
      tick();
    end
    a_valid = 1'b1; a_data = 8'h88;
    cyc();
    a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b1;
    look();
    chk("t4_data", out_data0, 16'h7788);
    chk("t4_src", 16'(out_src0), 16'h0);
    tick();
    do_clear();
    a_valid = 1'b1; a_data = 8'h9A;
    cyc();
    cyc();
    clear = 1'b1; a_data = 8'hBC;
    cyc();
    clear = 1'b0; a_valid = 1'b0;
    look();
    chk("t5_data", out_data0, 16'h0000);
    chk("t5_busy", 16'(busy0), 16'h0);
    chk("t5_valid", 16'(out_valid0), 16'h0);
    tick();
    a_valid = 1'b1; b_valid = 1'b1;
    cyc();
    look();
    chk("t5_tie_src", 16'(out_src0), 16'h0);
    tick();
    do_clear();
    a_valid = 1'b1; a_data = 8'h34;
    cyc();
    cyc();
    a_data = 8'h12;
    cyc();
    a_valid = 1'b0; out_ready = 1'b1;
    look();
    chk("t6_data_lowfirst", out_data1, 16'h1234);
    tick();
    for (int i = 0; i < 400; i++) begin
      clear     = ($urandom_range(0, 59) == 0);
      a_valid   = $urandom_range(0, 2) != 0;
      b_valid   = $urandom_range(0, 2) != 0;
      out_ready = $urandom_range(0, 1) != 0;
      a_data    = 8'($urandom);
      b_data    = 8'($urandom);
      cyc();
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/word_assembler_arb.md
Name: word_assembler_arb

Overview:
- Builds N-bit words from N/2-bit byte streams supplied by two requesters, A and B.
- Arbitrates ownership of the shared half-loadable word register between A and B, one whole word per grant, using round-robin.
- Sequences the high-half and low-half loads, then presents the completed word downstream with a valid/ready handshake.
- Sits between the byte-wide input sources and the word-wide datapath consumer.

Parameters:
- N, 16, output word width; must be even; each half is N/2 bits.
- HIGH_FIRST, 1, 1 = first accepted byte loads bits [N-1:N/2]; 0 = first byte loads [N/2-1:0].

Ports:
- clk  input  1  clock, rising edge.
- clear  input  1  reset, synchronous, active-high.
- a_valid  input  1  requester A byte valid.
- a_data  input  N/2  requester A byte.
- a_ready  output  1  A byte accepted this cycle when a_valid & a_ready.
- b_valid  input  1  requester B byte valid.
- b_data  input  N/2  requester B byte.
- b_ready  output  1  B byte accepted this cycle when b_valid & b_ready.
- out_valid  output  1  completed word available.
- out_data  output  N  word register contents.
- out_src  output  1  owner of the current/last word: 0 = A, 1 = B.
- out_ready  input  1  consumer accepts the word.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset: clk is the only clock; clear is synchronous and active-high. When clear is sampled high:
  - state = IDLE, word register = 0, out_src = 0, rr pointer = A.
  - out_valid, a_ready, b_ready and busy all 0 from the next cycle.
  - clear overrides every other input, including mid-word and while FULL; any partial word is discarded.
- States: IDLE, FIRST, SECOND, FULL.
- IDLE: waits for a_valid or b_valid.
  - On the next edge, grant is registered into out_src and state goes to FIRST.
  - If both are valid, the rr pointer decides; if only one is valid, that one wins regardless of pointer.
  - No byte is accepted in IDLE.
- FIRST: ready is asserted to the granted requester only; the other ready is held 0.
  - On handshake, load the first half (selected by HIGH_FIRST), hold the other half, go to SECOND.
- SECOND: same ready rule.
  - On handshake, load the remaining half and go to FULL.
  - The grant stays locked until the word completes. If the owner drops valid, the block waits indefinitely. There is no timeout, and the other requester is never granted mid-word.
- FULL: out_valid = 1; both readys are 0; out_data and out_src are stable.
  - On out_ready: go to IDLE and set the rr pointer to the requester other than out_src.
  - Without out_ready: hold (backpressure).
- out_data always reflects the register, including partial words. Consumers sample it only when out_valid is high.
- a_ready and b_ready are combinational from registered state and grant; they never depend on a_valid or b_valid.
- Latency: first byte is accepted 1 cycle after the request is seen in IDLE. out_valid rises the cycle after the second handshake.
- Throughput: at most 1 word per 4 cycles (IDLE, FIRST, SECOND, FULL).
- Half loads drive separate high and low enables. A half not loaded in a cycle holds its value. Widths are exact (N/2 into each half) with no extension.

Decomposition:
- Package word_asm_pkg:
  - typedef enum logic [1:0] state_t {IDLE, FIRST, SECOND, FULL};
  - typedef enum logic src_t {SRC_A, SRC_B};
- Sub-module rr_arb2: two-requester round-robin.
  - Inputs: req[1:0], ptr, update, clk, clear.
  - Outputs: gnt (src_t).
  - Holds the priority pointer.
- Word register, FSM and ready/valid logic live in the top module.

Test Plan:
1. clear; A sends 0x12 then 0x34, out_ready=1 -> out_data=0x1234, out_src=0, out_valid for exactly 1 cycle, 3 cycles after a_valid first seen in IDLE.
2. A and B both continuously valid, out_ready=1 -> out_src sequence is 0,1,0,1; each word correct (A: 0xA1A2, B: 0xB1B2); the non-granted ready is never high.
3. Word 0x5566 completes with out_ready=0 for 5 cycles -> out_valid held, out_data=0x5566 stable, a_ready=b_ready=0; releases the cycle out_ready=1.
4. A sends 0x77 and drops valid for 3 cycles while b_valid=1 -> state stays SECOND, b_ready=0; A resumes with 0x88 -> 0x7788, out_src=0.
5. clear asserted in SECOND after high byte 0x9A -> next cycle out_data=0x0000, busy=0, out_valid=0; a subsequent A/B tie grants A.
6. HIGH_FIRST=0: A sends 0x34 then 0x12 -> out_data=0x1234.
